mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer sharing one memory port between the instruction-fetch path and the load/store path of the multi-cycle core. Accepts one request at a time, forwards it to the memory port, waits for the response with a timeout, and routes the response back to its owner. Sits between the fetch unit, the load/store unit and the single memory backend.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

    // Sequencer states: accept a request, present it to memory, await the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Owner encoding, also used as the bit index into the one-hot grant vector.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Timeout counter width; TIMEOUT is bounded to 255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant among the fetch and load/store valids.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used this cycle.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       ifu_vld_i,
    input  logic       lsu_vld_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    // A lone requester always wins; on a tie the side that did not win last time goes.
    always_comb begin
        gnt_o = 2'b00;
        case ({lsu_vld_i, ifu_vld_i})
            2'b01:   gnt_o[OWN_IFU] = 1'b1;
            2'b10:   gnt_o[OWN_LSU] = 1'b1;
            2'b11: begin
                if (last_grant_i == OWN_LSU) begin
                    gnt_o[OWN_IFU] = 1'b1;
                end else begin
                    gnt_o[OWN_LSU] = 1'b1;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction in flight, with a response timeout.
// Latency: handshake in cycle 0, mem request in cycle 1, response pulse one cycle after mem_rsp_valid.
// Backpressure: request ready only in IDLE; mem_req_ready stalls REQ; responses cannot be backpressured.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_data,
    output logic                  ifu_rsp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_data,
    output logic                  lsu_rsp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wen_q, wen_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W/8-1:0]  wmask_q, wmask_d;

    logic                 ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic [DATA_W-1:0]    ifu_rsp_data_q, ifu_rsp_data_d;
    logic                 ifu_rsp_err_q, ifu_rsp_err_d;
    logic                 lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_W-1:0]    lsu_rsp_data_q, lsu_rsp_data_d;
    logic                 lsu_rsp_err_q, lsu_rsp_err_d;

    logic [1:0]           gnt;
    logic                 ifu_rdy, lsu_rdy;
    logic                 deliver, deliver_err;
    logic [DATA_W-1:0]    deliver_data;
    logic [CNT_W-1:0]     cnt_inc;

    rr_arb2 u_rr_arb2 (
        .ifu_vld_i    (ifu_req_valid),
        .lsu_vld_i    (lsu_req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, request latching and response generation for the three-state sequencer.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        ifu_rsp_valid_d = 1'b0;
        ifu_rsp_data_d  = ifu_rsp_data_q;
        ifu_rsp_err_d   = ifu_rsp_err_q;
        lsu_rsp_valid_d = 1'b0;
        lsu_rsp_data_d  = lsu_rsp_data_q;
        lsu_rsp_err_d   = lsu_rsp_err_q;
        ifu_rdy         = 1'b0;
        lsu_rdy         = 1'b0;
        deliver         = 1'b0;
        deliver_err     = 1'b0;
        deliver_data    = '0;

        case (state_q)
            ST_IDLE: begin
                // Ready is withheld during reset so no request is taken that the reset will drop.
                ifu_rdy = gnt[OWN_IFU] & ~rst;
                lsu_rdy = gnt[OWN_LSU] & ~rst;
                if (ifu_req_valid && ifu_rdy) begin
                    addr_d       = ifu_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    state_d      = ST_REQ;
                end else if (lsu_req_valid && lsu_rdy) begin
                    addr_d       = lsu_addr;
                    wen_d        = lsu_wen;
                    wdata_d      = lsu_wdata;
                    wmask_d      = lsu_wmask;
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response in the same cycle the counter would expire takes priority.
                if (mem_rsp_valid) begin
                    deliver      = 1'b1;
                    deliver_data = mem_rsp_data;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO) begin
                        deliver     = 1'b1;
                        deliver_err = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            if (owner_q == OWN_IFU) begin
                ifu_rsp_valid_d = 1'b1;
                ifu_rsp_data_d  = deliver_data;
                ifu_rsp_err_d   = deliver_err;
            end else begin
                lsu_rsp_valid_d = 1'b1;
                lsu_rsp_data_d  = deliver_data;
                lsu_rsp_err_d   = deliver_err;
            end
        end
    end

    // State, latched request and response registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_LSU;
            cnt_q           <= '0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= '0;
            ifu_rsp_err_q   <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_data_q  <= '0;
            lsu_rsp_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            ifu_rsp_data_q  <= ifu_rsp_data_d;
            ifu_rsp_err_q   <= ifu_rsp_err_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            lsu_rsp_data_q  <= lsu_rsp_data_d;
            lsu_rsp_err_q   <= lsu_rsp_err_d;
        end
    end

    assign ifu_req_ready = ifu_rdy;
    assign lsu_req_ready = lsu_rdy;

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rsp_data  = ifu_rsp_data_q;
    assign ifu_rsp_err   = ifu_rsp_err_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_data  = lsu_rsp_data_q;
    assign lsu_rsp_err   = lsu_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with TIMEOUT=4.
// Latency: checks the cycle-exact request/response timing.
// Backpressure: exercises mem_req_ready stalls and sustained request ties.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered at the negedge of the handshake cycle; returns at the negedge of the response cycle.
    task automatic xact(input string tg, input logic own_lsu, input logic [31:0] ea,
                        input logic ewen, input logic [31:0] ewd, input logic [3:0] ewm,
                        input logic [31:0] rd, input int stall, input logic drop);
        chk({tg, ":rdy"}, {lsu_req_ready, ifu_req_ready}, own_lsu ? 2'b10 : 2'b01);
        next_cycle();
        if (drop) begin
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
        end
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            @(negedge clk);
            chk({tg, ":req_vld"}, mem_req_valid, 1'b1);
            chk({tg, ":addr"}, mem_addr, ea);
            chk({tg, ":wen"}, mem_wen, ewen);
            chk({tg, ":wmask"}, mem_wmask, ewm);
            if (ewen) chk({tg, ":wdata"}, mem_wdata, ewd);
            chk({tg, ":rdy_req"}, {lsu_req_ready, ifu_req_ready}, 2'b00);
            next_cycle();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rd;
        @(negedge clk);
        chk({tg, ":req_vld_wait"}, mem_req_valid, 1'b0);
        chk({tg, ":rdy_wait"}, {lsu_req_ready, ifu_req_ready}, 2'b00);
        chk({tg, ":rsp_early"}, {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        @(negedge clk);
        chk({tg, ":rsp_vld"}, {lsu_rsp_valid, ifu_rsp_valid}, own_lsu ? 2'b10 : 2'b01);
        chk({tg, ":rsp_data"}, own_lsu ? lsu_rsp_data : ifu_rsp_data, rd);
        chk({tg, ":rsp_err"}, own_lsu ? lsu_rsp_err : ifu_rsp_err, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h0;
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 4'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst:valids", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
        chk("rst:readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
        chk("rst:errs", {ifu_rsp_err, lsu_rsp_err}, 2'b00);
        chk("rst:mem_fields", {mem_addr, mem_wdata}, 64'h0);
        chk("rst:rsp_data", {ifu_rsp_data, lsu_rsp_data}, 64'h0);

        // Sustained tie from reset: grant order I, L, I, L.
        next_cycle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_1000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_2000;
        @(negedge clk);
        xact("tie0_ifu", 1'b0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 32'h0000_0011, 0, 1'b0);
        xact("tie1_lsu", 1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 32'h0000_0022, 0, 1'b0);
        xact("tie2_ifu", 1'b0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 32'h0000_0033, 0, 1'b0);
        xact("tie3_lsu", 1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 32'h0000_0044, 0, 1'b1);

        // IFU alone, memory ready immediately.
        next_cycle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        @(negedge clk);
        xact("ifu_fetch", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("ifu_fetch:pulse", ifu_rsp_valid, 1'b0);
        chk("ifu_fetch:hold", ifu_rsp_data, 32'h0000_0413);

        // LSU store with mem_req_ready held low for 5 cycles.
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        xact("lsu_store", 1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'hA5A5_A5A5, 5, 1'b1);
        lsu_wen   = 1'b0;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'h0;

        // LSU load times out after 4 WAIT cycles; the late response is ignored.
        next_cycle();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_3000;
        @(negedge clk);
        chk("tmo:rdy", lsu_req_ready, 1'b1);
        next_cycle();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("tmo:quiet%0d", k), lsu_rsp_valid, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        chk("tmo:vld", lsu_rsp_valid, 1'b1);
        chk("tmo:err", lsu_rsp_err, 1'b1);
        chk("tmo:data", lsu_rsp_data, 32'h0);
        chk("tmo:ifu_quiet", ifu_rsp_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("tmo:pulse", lsu_rsp_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_5555;
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        @(negedge clk);
        chk("late:vlds", {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
        chk("late:lsu_err_hold", lsu_rsp_err, 1'b1);
        chk("late:lsu_data_hold", lsu_rsp_data, 32'h0);
        chk("late:mem_req", mem_req_valid, 1'b0);

        // IFU: response arrives in the cycle the counter would expire; real data wins.
        next_cycle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_4000;
        @(negedge clk);
        chk("race:rdy", ifu_req_ready, 1'b1);
        next_cycle();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("race:quiet%0d", k), ifu_rsp_valid, 1'b0);
            next_cycle();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0077;
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        @(negedge clk);
        chk("race:vld", ifu_rsp_valid, 1'b1);
        chk("race:err", ifu_rsp_err, 1'b0);
        chk("race:data", ifu_rsp_data, 32'h0000_0077);

        // Reset while in WAIT: everything clears, no response follows, next tie goes to IFU.
        next_cycle();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_6000;
        @(negedge clk);
        chk("rstw:rdy", lsu_req_ready, 1'b1);
        next_cycle();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw:valids", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
        chk("rstw:errs", {ifu_rsp_err, lsu_rsp_err}, 2'b00);
        chk("rstw:rsp_data", {ifu_rsp_data, lsu_rsp_data}, 64'h0);
        chk("rstw:mem_addr", mem_addr, 32'h0);
        chk("rstw:readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rstw:silent%0d", k), {lsu_rsp_valid, ifu_rsp_valid, mem_req_valid}, 3'b000);
        end
        next_cycle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_7000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_8000;
        @(negedge clk);
        xact("rstw_tie", 1'b0, 32'h0000_7000, 1'b0, 32'h0, 4'h0, 32'h0000_0099, 0, 1'b1);

        next_cycle();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
